// File: rtl/ctrl_pkg.sv
// ctrl_pkg: sequencer state encoding and layer_sel constants.
package ctrl_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT_ACK, DONE} seq_state_t;
  localparam logic [1:0] LAYER_L1 = 2'd0;
  localparam logic [1:0] LAYER_L2 = 2'd1;
  localparam logic [1:0] LAYER_L3 = 2'd2;
endpackage

// File: rtl/seq_delay_line.sv
// seq_delay_line: fixed-depth shift register with synchronous active-low clear.
module seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [DEPTH];
  always_ff @(posedge clk)
    if (!rst) for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: walks weight/bias addresses for three layers; PERF_CNT_EN adds cycle_count.
module inference_sequencer
  import ctrl_pkg::*;
#(
  parameter int NUM_NEURONS_L1 = 1024,
  parameter int NUM_NEURONS_L2 = 64,
  parameter int NUM_NEURONS_L3 = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int MEM_LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  layer_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  output logic [1:0]            layer_sel,
  output logic                  neuron_valid,
  output logic [ADDR_WIDTH-1:0] neuron_idx,
  output logic                  busy,
  output logic                  done
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);
  localparam logic [ADDR_WIDTH-1:0] LAST_L1 = ADDR_WIDTH'(NUM_NEURONS_L1 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_L2 = ADDR_WIDTH'(NUM_NEURONS_L2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_L3 = ADDR_WIDTH'(NUM_NEURONS_L3 - 1);
  seq_state_t            state;
  logic [2:0]            drain_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  last_issue;
  logic [ADDR_WIDTH:0]   dly_q;
  always_comb
    last_addr = layer_sel == LAYER_L1 ? LAST_L1 : layer_sel == LAYER_L2 ? LAST_L2 : LAST_L3;
  assign mem_ren    = state == FETCH && !stall;
  assign last_issue = mem_ren && mem_addr == last_addr;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  always_ff @(posedge clk)
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      layer_sel <= LAYER_L1;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            state     <= FETCH;
            mem_addr  <= '0;
            layer_sel <= LAYER_L1;
          end
        FETCH:
          if (mem_ren) begin
            mem_addr <= last_issue ? '0 : mem_addr + ADDR_WIDTH'(1);
            if (last_issue) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (drain_cnt == 3'(MEM_LATENCY - 1)) state <= WAIT_ACK;
        end
        WAIT_ACK:
          if (layer_ack) begin
            state     <= layer_sel == LAYER_L3 ? DONE : FETCH;
            layer_sel <= layer_sel == LAYER_L3 ? layer_sel : layer_sel + 2'd1;
            mem_addr  <= '0;
          end
        DONE: begin
          state     <= IDLE;
          layer_sel <= LAYER_L1;
        end
        default: state <= IDLE;
      endcase
    end
  // Reset clears the pipe so no stale read is reported after an abort.
  seq_delay_line #(.DEPTH(MEM_LATENCY), .WIDTH(ADDR_WIDTH + 1)) u_dly (
    .clk(clk),
    .rst(rst),
    .d  ({mem_ren, mem_addr}),
    .q  (dly_q)
  );
  assign neuron_valid = dly_q[ADDR_WIDTH];
  assign neuron_idx   = dly_q[ADDR_WIDTH-1:0];
`ifdef PERF_CNT_EN
  always_ff @(posedge clk)
    if (!rst) cycle_count <= '0;
    else if (state == IDLE && start) cycle_count <= '0;
    else if (busy && ~&cycle_count) cycle_count <= cycle_count + 32'd1;
`endif
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: directed scoreboard bench; define PERF_CNT_EN to cover cycle_count.
module tb_inference_sequencer;
  localparam int AW = 10;
  logic          clk = 0, rst = 0, start = 0, stall = 0, layer_ack = 0;
  logic [AW-1:0] mem_addr, neuron_idx;
  logic          mem_ren, neuron_valid, busy, done;
  logic [1:0]    layer_sel;
`ifdef PERF_CNT_EN
  logic [31:0]   cycle_count;
`endif
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [1:0] layer; logic [AW-1:0] idx; int at;} exp_t;
  exp_t exp_q[$];

  inference_sequencer #(
    .NUM_NEURONS_L1(4), .NUM_NEURONS_L2(3), .NUM_NEURONS_L3(2),
    .ADDR_WIDTH(AW), .MEM_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .layer_ack(layer_ack),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .layer_sel(layer_sel),
    .neuron_valid(neuron_valid), .neuron_idx(neuron_idx), .busy(busy), .done(done)
`ifdef PERF_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented neuron must match the oldest expected issue.
  always @(negedge clk) begin
    #2;
    if (neuron_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(neuron_valid), 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_idx", 32'(neuron_idx), 32'(e.idx));
        chk("valid_layer", 32'(layer_sel), 32'(e.layer));
        chk("valid_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic cyc_chk(input logic s_start, input logic s_stall, input logic s_ack,
                         input logic e_ren, input int e_addr, input int e_layer,
                         input logic e_busy, input logic e_done);
    start = s_start;
    stall = s_stall;
    layer_ack = s_ack;
    #1;
    chk("mem_ren", 32'(mem_ren), 32'(e_ren));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("layer_sel", 32'(layer_sel), 32'(e_layer));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (e_ren) exp_q.push_back('{layer: 2'(e_layer), idx: AW'(e_addr), at: cyc + 2});
    @(negedge clk);
  endtask

  task automatic run_inference(input int stall_len, input int aw, input logic noise);
    int n[3] = '{4, 3, 2};
    cyc_chk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int l = 0; l < 3; l++) begin
      for (int a = 0; a < n[l]; a++) begin
        if (l == 0 && a == 2) repeat (stall_len) cyc_chk(noise, 1, noise, 0, a, l, 1, 0);
        cyc_chk(noise, 0, noise, 1, a, l, 1, 0);
      end
      repeat (2) cyc_chk(noise, noise, noise, 0, 0, l, 1, 0);
      repeat (aw) cyc_chk(0, 0, 0, 0, 0, l, 1, 0);
      cyc_chk(0, 0, 1, 0, 0, l, 1, 0);
    end
    cyc_chk(0, 0, 0, 0, 0, 2, 1, 1);
    cyc_chk(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PERF_CNT_EN
    chk("cycle_count", cycle_count, 32'(9 + stall_len + 6 + 3 * (aw + 1) + 1));
    repeat (3) @(negedge clk);
    chk("cycle_count_hold", cycle_count, 32'(9 + stall_len + 6 + 3 * (aw + 1) + 1));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    #1;
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_ren"}, 32'(mem_ren), 32'd0);
    chk({tag, "_layer"}, 32'(layer_sel), 32'd0);
    chk({tag, "_valid"}, 32'(neuron_valid), 32'd0);
    chk({tag, "_idx"}, 32'(neuron_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1;
    @(negedge clk);
    run_inference(0, 1, 0);
    run_inference(3, 1, 0);
    run_inference(0, 3, 1);
    // Abort in layer 2 with mem_addr=1, then restart from scratch.
    cyc_chk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) cyc_chk(0, 0, 0, 1, a, 0, 1, 0);
    repeat (2) cyc_chk(0, 0, 0, 0, 0, 0, 1, 0);
    cyc_chk(0, 0, 1, 0, 0, 0, 1, 0);
    cyc_chk(0, 0, 0, 1, 0, 1, 1, 0);
    #1;
    chk("pre_rst_addr", 32'(mem_addr), 32'd1);
    chk("pre_rst_layer", 32'(layer_sel), 32'd1);
    rst = 0;
    @(negedge clk);
    exp_q.delete();
    rst = 1;
    chk_all_zero("abort");
    @(negedge clk);
    repeat (4) cyc_chk(0, 0, 0, 0, 0, 0, 0, 0);
    run_inference(0, 0, 0);
    repeat (4) @(negedge clk);
    chk("queue_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
